ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port data RAM between two requesters: m0 (CPU data port) and m1 (program
//  loader / debug port). Round-robin arbitration, one access per cycle, optional locked bursts
//  bounded by a hold counter. Sits between the requesters and the RAM; read data returns 1 cycle
//  after grant, matching the RAM's registered read.
// PARAMETERS
//  ADDR_W    22  RAM word-address width
//  MAX_LOCK  16  max cycles a master may hold a lock before being forced out (>=2)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  m<i>_req     in   1       i=0,1: access request; hold all m<i>_* inputs stable until m<i>_gnt
//  m<i>_lock    in   1       request lock (keep ownership after this access)
//  m<i>_wen     in   4       byte write enables; 4'b0000 = read
//  m<i>_addr    in   ADDR_W  word address
//  m<i>_wdata   in   32      write data
//  m<i>_gnt     out  1       access accepted this cycle (combinational from req/state)
//  m<i>_rvalid  out  1       registered; read data valid on m<i>_rdata this cycle
//  m<i>_rdata   out  32      = ram_rdata (meaningful only while m<i>_rvalid)
//  ram_wen      out  4       to RAM byte write enables
//  ram_addr     out  ADDR_W  to RAM address
//  ram_wdata    out  32      to RAM write data
//  ram_rdata    in   32      from RAM, registered read (1-cycle latency)
// BEHAVIOUR
//  - State: ARB, LOCK0, LOCK1; regs last (last granted master), lock_cnt, rv0, rv1.
//  - Reset: state=ARB, last=1 (m0 wins the first tie), lock_cnt=0, m0/m1_rvalid=0. While rst=1:
//    m0/m1_gnt=0, ram_wen=0. Reset mid-burst drops the lock; a pending rvalid is discarded.
//  - ARB: one req -> grant it; both -> grant the master != last; none -> no grant.
//  - LOCKi: only mi may be granted; m(1-i)_gnt=0 even if requesting.
//  - At most one gnt per cycle. On a grant to mi: ram_* = mi_*, last<=i.
//    No grant: ram_wen=0, ram_addr=0, ram_wdata=0.
//  - Read (wen==0) granted in cycle N -> mi_rvalid=1 in cycle N+1, exactly one cycle.
//    Writes never raise rvalid. Back-to-back reads give rvalid on consecutive cycles.
//  - Lock entry: in ARB, a grant to mi with mi_lock=1 -> LOCKi next cycle, lock_cnt<=0.
//  - In LOCKi: lock_cnt increments every cycle (granted or not).
//    Exit to ARB next cycle when: (a) granted with mi_lock=0, (b) mi_req=0, or
//    (c) lock_cnt==MAX_LOCK-1 (forced exit, even if mi_lock=1).
//  - After any exit, last=i, so the other master wins the next tie.
//    A forced-out master needs a fresh grant to lock again.
//  - A write followed by a read of the same address in the next cycle returns the new data
//    (RAM ordering); the arbiter adds no buffering or reordering.
//  - Address width: ram_addr is passed unchanged; no decode or range checking.
// TESTING
//  1 Reset, then m0 read addr 5 (mem[5]=32'hA5A5_0001) -> m0_gnt same cycle,
//    m0_rvalid=1 with rdata A5A5_0001 next cycle, m1_rvalid=0.
//  2 m0 and m1 both request continuously (no lock) -> grants alternate m0,m1,m0,m1...
//    ram_addr follows the granted master every cycle.
//  3 m1 write wen=4'b0011 wdata=32'h1234_5678 to addr 9 (old 0xFFFF_FFFF), then m0 reads 9 ->
//    0xFFFF_5678, no rvalid on the write.
//  4 m1 lock=1 burst, m0 requesting, MAX_LOCK=16 -> m1 granted 16 consecutive cycles,
//    then m0 granted; m0_gnt=0 throughout the lock.
//  5 m0 locked, drops lock on its 3rd access -> state ARB next cycle, m1 granted next.
//  6 rst asserted in the cycle after a m0 read grant -> m0_rvalid stays 0, both gnt=0
//    while in reset, m0 wins first tie after reset.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between two masters,
// with bounded locked bursts and a one-cycle registered read-valid return.
module ram_arbiter #(
  parameter int ADDR_W   = 22,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [3:0]        m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [3:0]        m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t                   state;
  logic                     last;
  logic [CW-1:0]            lock_cnt;
  logic [1:0]               rv;
  logic [1:0]               req, lock, gnt, rd;
  logic [1:0][3:0]          wen;
  logic [1:0][ADDR_W-1:0]   addr;
  logic [1:0][31:0]         wdata;
  logic                     own, sel;

  assign req   = {m1_req, m0_req};
  assign lock  = {m1_lock, m0_lock};
  assign wen   = {m1_wen, m0_wen};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};
  assign rd    = {m1_wen == 4'h0, m0_wen == 4'h0};
  assign own   = (state == LOCK1);
  assign sel   = gnt[1];

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (state)
        ARB: begin
          // last==1 means m1 went most recently, so m0 takes the tie
          if (req[0] && (!req[1] || last)) gnt[0] = 1'b1;
          else if (req[1])                 gnt[1] = 1'b1;
        end
        LOCK0:   gnt[0] = req[0];
        LOCK1:   gnt[1] = req[1];
        default: gnt = 2'b00;
      endcase
    end
  end

  assign ram_wen   = (|gnt) ? wen[sel]   : 4'h0;
  assign ram_addr  = (|gnt) ? addr[sel]  : '0;
  assign ram_wdata = (|gnt) ? wdata[sel] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      last     <= 1'b1;
      lock_cnt <= '0;
      rv       <= 2'b00;
    end else begin
      rv <= gnt & rd;
      if (|gnt) last <= gnt[1];
      unique case (state)
        ARB: begin
          if (gnt[0] && lock[0]) begin
            state    <= LOCK0;
            lock_cnt <= '0;
          end else if (gnt[1] && lock[1]) begin
            state    <= LOCK1;
            lock_cnt <= '0;
          end
        end
        LOCK0, LOCK1: begin
          lock_cnt <= lock_cnt + 1'b1;
          if ((gnt[own] && !lock[own]) || !req[own] ||
              lock_cnt == CW'(MAX_LOCK - 1)) begin
            state <= ARB;
            last  <= own;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  // a read return still pending when reset hits is dropped
  assign m0_rvalid = rv[0] & ~rst;
  assign m1_rvalid = rv[1] & ~rst;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic checked
// against an ownership/round-robin reference model and a behavioural RAM.
module tb_ram_arbiter;
  localparam int AW = 22;
  localparam int ML = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         req, lock;
  logic [1:0][3:0]    wen;
  logic [1:0][AW-1:0] addr;
  logic [1:0][31:0]   wdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [3:0]  ram_wen;
  logic [AW-1:0] ram_addr;

  ram_arbiter #(.ADDR_W(AW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_wen(wen[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_wen(wen[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // behavioural RAM: byte-enable write, registered read
  logic [31:0] mem [64];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr[5:0]];
  end

  // reference model: who owns the RAM, how long, who went last
  logic [31:0] ref_mem [64];
  bit          m_busy, m_own, m_last;
  int          m_held;
  bit [1:0]    m_pend;
  logic [31:0] m_pdata;
  logic [1:0]  eg, e_rv;
  bit          gi;
  logic [3:0]  e_wen;
  logic [AW-1:0] e_addr;
  logic [31:0] e_wdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    eg = 2'b00;
    if (!rst) begin
      if (m_busy)            eg[m_own] = req[m_own];
      else if (req == 2'b11) begin if (m_last) eg[0] = 1'b1; else eg[1] = 1'b1; end
      else                   eg = req;
    end
    gi      = eg[1];
    e_wen   = (eg != 2'b00) ? wen[gi]   : 4'h0;
    e_addr  = (eg != 2'b00) ? addr[gi]  : '0;
    e_wdata = (eg != 2'b00) ? wdata[gi] : 32'h0;
    e_rv    = rst ? 2'b00 : m_pend;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_held <= 0; m_last <= 1'b1; m_pend <= 2'b00;
    end else begin
      m_pend <= eg & {wen[1] == 4'h0, wen[0] == 4'h0};
      if (eg != 2'b00) begin
        m_pdata <= ref_mem[e_addr[5:0]];
        if (e_wen != 4'h0) ref_mem[e_addr[5:0]] <= merge(ref_mem[e_addr[5:0]], e_wdata, e_wen);
        m_last <= gi;
      end
      if (!m_busy) begin
        if (eg != 2'b00 && lock[gi]) begin m_busy <= 1'b1; m_own <= gi; m_held <= 0; end
      end else if (!req[m_own] || (eg[m_own] && !lock[m_own]) || m_held + 1 == ML) begin
        m_busy <= 1'b0; m_last <= m_own;
      end else m_held <= m_held + 1;
    end
  end

  int passed = 0, total = 0;

  task automatic idle();
    req = 2'b00; lock = 2'b00; wen = '0; addr = '0; wdata = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    next_cyc(); next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); req = 2'b11;
    next_cyc();
    @(negedge clk);
    total++; if (m0_gnt !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", m0_gnt); else passed++;
    total++; if (m1_gnt !== 1'b0) $display("FAIL rst_gnt1: got %b want 0", m1_gnt); else passed++;
    total++; if (ram_wen !== 4'h0) $display("FAIL rst_wen: got %h want 0", ram_wen); else passed++;
    total++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {m1_rvalid, m0_rvalid}); else passed++;
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    req[0] = 1'b1; addr[0] = 5;
    @(negedge clk);
    total++; if (m0_gnt !== 1'b1) $display("FAIL rd_gnt: got %b want 1", m0_gnt); else passed++;
    total++; if (ram_addr !== AW'(5)) $display("FAIL rd_addr: got %h want 5", ram_addr); else passed++;
    next_cyc(); idle();
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b want 1", m0_rvalid); else passed++;
    total++; if (m0_rdata !== 32'hA5A5_0001) $display("FAIL rd_data: got %h want a5a50001", m0_rdata); else passed++;
    total++; if (m1_rvalid !== 1'b0) $display("FAIL rd_m1_rvalid: got %b want 0", m1_rvalid); else passed++;
    next_cyc();
  endtask

  task automatic test_alternate();
    bit w0;
    do_reset();
    req = 2'b11; addr[0] = AW'(10); addr[1] = AW'(20);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w0 = (k % 2 == 0);
      total++; if ({m1_gnt, m0_gnt} !== {~w0, w0}) $display("FAIL alt_gnt[%0d]: got %b want %b", k, {m1_gnt, m0_gnt}, {~w0, w0}); else passed++;
      total++; if (ram_addr !== (w0 ? AW'(10) : AW'(20))) $display("FAIL alt_addr[%0d]: got %0d want %0d", k, ram_addr, w0 ? 10 : 20); else passed++;
      next_cyc();
    end
    idle(); next_cyc();
  endtask

  task automatic test_write_read();
    do_reset();
    req[1] = 1'b1; wen[1] = 4'b0011; addr[1] = AW'(9); wdata[1] = 32'h1234_5678;
    @(negedge clk);
    total++; if (m1_gnt !== 1'b1) $display("FAIL wr_gnt: got %b want 1", m1_gnt); else passed++;
    total++; if (ram_wen !== 4'b0011) $display("FAIL wr_wen: got %b want 0011", ram_wen); else passed++;
    next_cyc();
    idle(); req[0] = 1'b1; addr[0] = AW'(9);
    @(negedge clk);
    total++; if (m0_gnt !== 1'b1) $display("FAIL wr_rd_gnt: got %b want 1", m0_gnt); else passed++;
    total++; if (m1_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b want 0", m1_rvalid); else passed++;
    next_cyc(); idle();
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b1) $display("FAIL wr_rd_rvalid: got %b want 1", m0_rvalid); else passed++;
    total++; if (m0_rdata !== 32'hFFFF_5678) $display("FAIL wr_rd_data: got %h want ffff5678", m0_rdata); else passed++;
    next_cyc();
  endtask

  task automatic test_lock_burst();
    int streak = 0;
    bit seen0 = 1'b0, g1_at = 1'b0;
    do_reset();
    req[1] = 1'b1; lock[1] = 1'b1; addr[1] = AW'(48);
    @(negedge clk);
    total++; if (m1_gnt !== 1'b1) $display("FAIL lk_entry: got %b want 1", m1_gnt); else passed++;
    next_cyc();
    req[0] = 1'b1; addr[0] = AW'(49);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m0_gnt) begin seen0 = 1'b1; g1_at = m1_gnt; break; end
      if (m1_gnt) streak++;
      next_cyc();
    end
    total++; if (streak != ML) $display("FAIL lk_streak: got %0d want %0d", streak, ML); else passed++;
    total++; if (!seen0 || g1_at) $display("FAIL lk_handover: got m0 %b m1 %b want 1 0", seen0, g1_at); else passed++;
    next_cyc(); idle(); next_cyc();
  endtask

  task automatic test_lock_release();
    do_reset();
    req = 2'b11; lock[0] = 1'b1; addr[0] = AW'(40); addr[1] = AW'(41);
    for (int a = 1; a <= 3; a++) begin
      if (a == 3) lock[0] = 1'b0;
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL rel_acc%0d: got %b want 01", a, {m1_gnt, m0_gnt}); else passed++;
      next_cyc();
    end
    @(negedge clk);
    total++; if ({m1_gnt, m0_gnt} !== 2'b10) $display("FAIL rel_next: got %b want 10", {m1_gnt, m0_gnt}); else passed++;
    next_cyc(); idle(); next_cyc();
  endtask

  task automatic test_reset_midread();
    do_reset();
    req[0] = 1'b1; addr[0] = AW'(5);
    @(negedge clk);
    total++; if (m0_gnt !== 1'b1) $display("FAIL mr_gnt: got %b want 1", m0_gnt); else passed++;
    next_cyc();
    rst = 1'b1; req = 2'b11;
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b0) $display("FAIL mr_rvalid: got %b want 0", m0_rvalid); else passed++;
    total++; if ({m1_gnt, m0_gnt} !== 2'b00) $display("FAIL mr_gnt_rst: got %b want 00", {m1_gnt, m0_gnt}); else passed++;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    total++; if ({m1_gnt, m0_gnt} !== 2'b01) $display("FAIL mr_tie: got %b want 01", {m1_gnt, m0_gnt}); else passed++;
    next_cyc(); idle(); next_cyc();
  endtask

  task automatic test_random();
    logic [1:0] took = 2'b11;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i] || took[i]) begin
          req[i]   = ($urandom % 3) != 0;
          lock[i]  = $urandom % 2;
          wen[i]   = ($urandom % 2) ? 4'h0 : 4'($urandom);
          addr[i]  = ($urandom % 8 == 0) ? AW'($urandom) : AW'($urandom % 64);
          wdata[i] = $urandom;
        end
      end
      rst = ($urandom % 97 == 0);
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== eg) $display("FAIL rnd_gnt@%0d: got %b want %b", c, {m1_gnt, m0_gnt}, eg); else passed++;
      total++; if (ram_wen !== e_wen) $display("FAIL rnd_wen@%0d: got %h want %h", c, ram_wen, e_wen); else passed++;
      total++; if (ram_addr !== e_addr) $display("FAIL rnd_addr@%0d: got %h want %h", c, ram_addr, e_addr); else passed++;
      total++; if (ram_wdata !== e_wdata) $display("FAIL rnd_wdata@%0d: got %h want %h", c, ram_wdata, e_wdata); else passed++;
      total++; if ({m1_rvalid, m0_rvalid} !== e_rv) $display("FAIL rnd_rvalid@%0d: got %b want %b", c, {m1_rvalid, m0_rvalid}, e_rv); else passed++;
      if (e_rv[0]) begin
        total++; if (m0_rdata !== m_pdata) $display("FAIL rnd_rdata0@%0d: got %h want %h", c, m0_rdata, m_pdata); else passed++;
      end
      if (e_rv[1]) begin
        total++; if (m1_rdata !== m_pdata) $display("FAIL rnd_rdata1@%0d: got %h want %h", c, m1_rdata, m_pdata); else passed++;
      end
      took = eg;
      next_cyc();
    end
    rst = 1'b0; idle(); next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    mem[5] = 32'hA5A5_0001; ref_mem[5] = 32'hA5A5_0001;
    mem[9] = 32'hFFFF_FFFF; ref_mem[9] = 32'hFFFF_FFFF;
    rst = 1'b1; idle();
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_lock_burst();
    test_lock_release();
    test_reset_midread();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
